// File: rtl/dot_product_sequencer.sv
// Control sequencer for one dot-product job: CLEAR, LOAD, GAP, COMPUTE, DONE (31 cycles default).
// Moore outputs only; LOAD stalls indefinitely on beat_valid=0; abort and reset cancel with no done pulse.
module dot_product_sequencer #(
   parameter int Addr_Width              = 4,
   parameter int Ram_Depth               = 1 << Addr_Width,
   parameter int Para_Deg                = 2,
   parameter int Nums_Data_in_bits       = 4,
   parameter int Total_Computation_Steps = 19,
   parameter int Gap_Cycles              = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic                         accumulate,
   input  logic                         skip_load,
   input  logic                         abort,
   input  logic                         beat_valid,
   output logic                         beat_ready,
   output logic                         Mem_reset,
   output logic                         Comp_reset,
   output logic                         PE_reset,
   output logic                         Mem_Index_reset,
   output logic                         load_from_file,
   output logic                         Computing,
   output logic                         load_old_output,
   output logic                         busy,
   output logic                         done,
   output logic [2:0]                   state,
   output logic [Nums_Data_in_bits:0]   step_count
);

   localparam int Beats = Ram_Depth / Para_Deg;
   localparam int StepW = Nums_Data_in_bits + 1;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CLEAR   = 3'd1,
      S_LOAD    = 3'd2,
      S_GAP     = 3'd3,
      S_COMPUTE = 3'd4,
      S_DONE    = 3'd5
   } state_t;

   state_t                state_q, state_d;
   logic [Addr_Width-1:0] beat_cnt;
   logic [StepW-1:0]      step_cnt;
   logic                  acc_q, skip_q, rst_q;
   logic                  beat_fire, last_beat, gap_end, comp_end, job_go;

   assign job_go    = (state_q == S_IDLE) && start && !abort;
   assign beat_fire = (state_q == S_LOAD) && beat_valid;
   assign last_beat = beat_fire && (beat_cnt == Addr_Width'(Beats - 1));
   assign gap_end   = (state_q == S_GAP) && (step_cnt == StepW'(Gap_Cycles - 1));
   assign comp_end  = (state_q == S_COMPUTE) && (step_cnt == StepW'(Total_Computation_Steps - 1));

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (job_go) state_d = S_CLEAR;
         S_CLEAR:   state_d = skip_q ? S_GAP : S_LOAD;
         S_LOAD:    if (last_beat) state_d = S_GAP;
         S_GAP:     if (gap_end) state_d = S_COMPUTE;
         S_COMPUTE: if (comp_end) state_d = S_DONE;
         S_DONE:    state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
      if (abort && (state_q != S_IDLE)) state_d = S_IDLE;
   end

   // Counters restart on every state change so GAP and COMPUTE share the step counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         beat_cnt <= '0;
         step_cnt <= '0;
         acc_q    <= 1'b0;
         skip_q   <= 1'b0;
      end else begin
         if (state_d != state_q) begin
            beat_cnt <= '0;
            step_cnt <= '0;
         end else begin
            if (beat_fire) beat_cnt <= beat_cnt + Addr_Width'(1);
            if ((state_q == S_GAP) || (state_q == S_COMPUTE)) step_cnt <= step_cnt + StepW'(1);
         end
         if (job_go) begin
            acc_q  <= accumulate;
            skip_q <= skip_load;
         end
      end
   end

   // Registered copy of reset keeps the datapath resets free of a combinational input path.
   always_ff @(posedge clk) begin
      rst_q <= reset;
   end

   always_comb begin
      Mem_reset       = rst_q;
      Comp_reset      = rst_q;
      PE_reset        = rst_q;
      Mem_Index_reset = rst_q;
      beat_ready      = 1'b0;
      load_from_file  = 1'b0;
      Computing       = 1'b0;
      load_old_output = 1'b0;
      done            = 1'b0;
      case (state_q)
         S_CLEAR: begin
            Mem_reset       = rst_q || !skip_q;
            Comp_reset      = 1'b1;
            PE_reset        = 1'b1;
            Mem_Index_reset = 1'b1;
         end
         S_LOAD: begin
            beat_ready     = 1'b1;
            load_from_file = 1'b1;
         end
         S_GAP:     Mem_Index_reset = rst_q || (step_cnt == '0);
         S_COMPUTE: begin
            Computing       = 1'b1;
            load_old_output = acc_q;
         end
         S_DONE:    done = 1'b1;
         default:   ;
      endcase
   end

   assign busy       = (state_q != S_IDLE);
   assign state      = state_q;
   assign step_count = (state_q == S_COMPUTE) ? step_cnt : '0;

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Directed jobs; a negedge monitor measures each job and checks it against queued expectations on done.
module tb_dot_product_sequencer;

   logic       clk, reset, start, accumulate, skip_load, abort, beat_valid;
   logic       beat_ready, Mem_reset, Comp_reset, PE_reset, Mem_Index_reset;
   logic       load_from_file, Computing, load_old_output, busy, done;
   logic [2:0] state;
   logic [4:0] step_count;

   dot_product_sequencer dut (
      .clk(clk), .reset(reset), .start(start), .accumulate(accumulate),
      .skip_load(skip_load), .abort(abort), .beat_valid(beat_valid),
      .beat_ready(beat_ready), .Mem_reset(Mem_reset), .Comp_reset(Comp_reset),
      .PE_reset(PE_reset), .Mem_Index_reset(Mem_Index_reset),
      .load_from_file(load_from_file), .Computing(Computing),
      .load_old_output(load_old_output), .busy(busy), .done(done),
      .state(state), .step_count(step_count)
   );

   typedef struct {
      int load_cyc;
      int gap_cyc;
      int comp_cyc;
      int beats;
      int mem_rst;
      int pe_rst;
      int mir;
      int old_out;
      int done_cyc;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string name, input int act, input int expv);
      n_checks++;
      if (act != expv) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, expv);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: bound expired", name);
   endtask

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Monitor: accumulates per-job measurements from CLEAR onward, compares at done.
   initial begin
      exp_t e;
      int cyc, ld, gp, cp, bt, mr, pr, mir, old;
      cyc = 0; ld = 0; gp = 0; cp = 0; bt = 0; mr = 0; pr = 0; mir = 0; old = 0;
      forever begin
         @(negedge clk);
         check("busy_decode", int'(busy), int'(state != 3'd0));
         if (!Computing) check("step_idle_zero", int'(step_count), 0);
         if (state == 3'd1) begin
            cyc = 1; ld = 0; gp = 0; cp = 0; bt = 0; old = 0;
            mr = int'(Mem_reset); pr = int'(PE_reset); mir = int'(Mem_Index_reset);
         end else begin
            cyc++;
            if (state == 3'd2) ld++;
            if (state == 3'd3) gp++;
            if (Computing) begin
               check("step_count_seq", int'(step_count), cp);
               cp++;
            end
            if (beat_valid && beat_ready) bt++;
            if (Mem_reset) mr++;
            if (PE_reset) pr++;
            if (Mem_Index_reset) mir++;
            if (load_old_output) old++;
         end
         if (done) begin
            if (exp_q.size() == 0) begin
               fail_now("unexpected_done");
            end else begin
               e = exp_q.pop_front();
               check("load_cycles", ld, e.load_cyc);
               check("gap_cycles", gp, e.gap_cyc);
               check("computing_cycles", cp, e.comp_cyc);
               check("beats_accepted", bt, e.beats);
               check("mem_reset_cycles", mr, e.mem_rst);
               check("pe_reset_cycles", pr, e.pe_rst);
               check("mem_index_reset_cycles", mir, e.mir);
               check("load_old_output_cycles", old, e.old_out);
               check("done_cycle", cyc, e.done_cyc);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input logic acc, input logic skip);
      accumulate = acc;
      skip_load  = skip;
      start      = 1'b1;
      tick();
      start      = 1'b0;
      accumulate = 1'b0;
      skip_load  = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 200; i++) begin
         if (state == 3'd0) return;
         tick();
      end
      fail_now(name);
   endtask

   task automatic wait_step(input int st, input int step, input string name);
      for (int i = 0; i < 200; i++) begin
         if ((int'(state) == st) && (int'(step_count) == step)) return;
         tick();
      end
      fail_now(name);
   endtask

   task automatic push(input int ld, input int bt, input int mr, input int old, input int dc);
      exp_t e;
      e.load_cyc = ld; e.gap_cyc = 2; e.comp_cyc = 19; e.beats = bt;
      e.mem_rst = mr; e.pe_rst = 1; e.mir = 2; e.old_out = old; e.done_cyc = dc;
      exp_q.push_back(e);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; accumulate = 1'b0; skip_load = 1'b0;
      abort = 1'b0; beat_valid = 1'b0;
      tick(); tick();
      check("rst_state", int'(state), 0);
      check("rst_Mem_reset", int'(Mem_reset), 1);
      check("rst_Comp_reset", int'(Comp_reset), 1);
      check("rst_PE_reset", int'(PE_reset), 1);
      check("rst_Mem_Index_reset", int'(Mem_Index_reset), 1);
      check("rst_beat_ready", int'(beat_ready), 0);
      check("rst_Computing", int'(Computing), 0);
      check("rst_done", int'(done), 0);
      reset = 1'b0;
      tick();
      check("post_rst_Mem_reset", int'(Mem_reset), 0);
      check("post_rst_PE_reset", int'(PE_reset), 0);

      // Full job, beats always offered.
      beat_valid = 1'b1;
      push(8, 8, 1, 0, 31);
      pulse_start(1'b0, 1'b0);
      check("clear_after_start", int'(state), 1);
      wait_idle("full_job_idle");
      tick();

      // Three stall cycles after the fourth beat.
      push(11, 8, 1, 0, 34);
      pulse_start(1'b0, 1'b0);
      tick();
      check("stall_in_load", int'(state), 2);
      for (int i = 0; i < 4; i++) tick();
      beat_valid = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      check("stall_hold_load", int'(state), 2);
      beat_valid = 1'b1;
      wait_idle("stall_job_idle");
      tick();

      // Reuse SRAM contents and accumulate onto the old output.
      push(0, 0, 0, 19, 23);
      pulse_start(1'b1, 1'b1);
      tick();
      check("skip_goes_gap", int'(state), 3);
      wait_idle("skip_job_idle");
      tick();

      // Abort at COMPUTE step 5, then a clean job.
      pulse_start(1'b0, 1'b0);
      wait_step(4, 5, "abort_wait_step5");
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_state", int'(state), 0);
      check("abort_Computing", int'(Computing), 0);
      check("abort_busy", int'(busy), 0);
      check("abort_old_output", int'(load_old_output), 0);
      tick(); tick();
      push(8, 8, 1, 0, 31);
      pulse_start(1'b0, 1'b0);
      wait_idle("post_abort_idle");
      tick();

      // Reset mid-LOAD after four beats.
      pulse_start(1'b0, 1'b0);
      tick();
      for (int i = 0; i < 4; i++) tick();
      check("pre_reset_load", int'(state), 2);
      reset = 1'b1;
      tick();
      check("midrst_state", int'(state), 0);
      check("midrst_Mem_reset", int'(Mem_reset), 1);
      check("midrst_Comp_reset", int'(Comp_reset), 1);
      check("midrst_PE_reset", int'(PE_reset), 1);
      check("midrst_Mem_Index_reset", int'(Mem_Index_reset), 1);
      check("midrst_beat_ready", int'(beat_ready), 0);
      reset = 1'b0;
      tick();
      check("midrst_release", int'(Mem_reset), 0);
      push(8, 8, 1, 0, 31);
      pulse_start(1'b0, 1'b0);
      wait_idle("post_reset_idle");
      tick();

      // Start with abort in IDLE is ignored; start pulses while busy are ignored.
      start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      check("start_abort_ignored", int'(state), 0);
      tick();
      check("start_abort_still_idle", int'(state), 0);
      push(8, 8, 1, 0, 31);
      pulse_start(1'b0, 1'b0);
      tick(); tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_step(4, 3, "busy_start_wait");
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_idle("busy_start_idle");
      tick(); tick();
      check("no_restart_after_busy_start", int'(state), 0);

      check("queue_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dot_product_sequencer.md
DOT_PRODUCT_SEQUENCER -- requirements
Module: dot_product_sequencer

Interface
REQ-001 SHALL have parameter Addr_Width, 4, SRAM address width.
REQ-002 SHALL have parameter Ram_Depth, 1<<Addr_Width, words per SRAM.
REQ-003 SHALL have parameter Para_Deg, 2, words transferred per load beat.
REQ-004 SHALL have parameter Nums_Data_in_bits, 4, log2 of the vector length.
REQ-005 SHALL have parameter Total_Computation_Steps, 19, Computing cycles per job (Nums_Data + Pipeline_Tail).
REQ-006 SHALL have parameter Gap_Cycles, 2, idle cycles between load and compute.
REQ-007 SHALL have port clk, input, 1, the single clock; all logic on the rising edge.
REQ-008 SHALL have port reset, input, 1, synchronous, active-high.
REQ-009 SHALL have port start, input, 1, job request; sampled in IDLE only.
REQ-010 SHALL have port accumulate, input, 1, sampled with start; 1 = add to old output.
REQ-011 SHALL have port skip_load, input, 1, sampled with start; 1 = reuse SRAM contents.
REQ-012 SHALL have port abort, input, 1, cancels the job.
REQ-013 SHALL have port beat_valid, input, 1, host presents one load beat.
REQ-014 SHALL have port beat_ready, output, 1, sequencer accepts a beat.
REQ-015 SHALL have ports Mem_reset, Comp_reset, PE_reset, Mem_Index_reset, output, 1 each, datapath resets.
REQ-016 SHALL have ports load_from_file, Computing, load_old_output, output, 1 each, datapath controls.
REQ-017 SHALL have port busy, output, 1, high when the state is not IDLE.
REQ-018 SHALL have port done, output, 1, one-cycle job-complete pulse.
REQ-019 SHALL have port state, output, 3, encoding IDLE=0, CLEAR=1, LOAD=2, GAP=3, COMPUTE=4, DONE=5.
REQ-020 SHALL have port step_count, output, Nums_Data_in_bits+1, current COMPUTE step.

Function
REQ-021 SHALL make every output a decode of the state register and counters only (Moore), with no input-to-output combinational path.
REQ-022 SHALL, in IDLE on start=1, latch accumulate and skip_load and enter CLEAR on the next edge.
REQ-023 SHALL, in CLEAR for exactly 1 cycle, assert Comp_reset, PE_reset and Mem_Index_reset; Mem_reset SHALL also be asserted only when skip_load was latched 0.
REQ-024 SHALL leave CLEAR for LOAD when skip_load=0, or for GAP when skip_load=1.
REQ-025 SHALL, in LOAD, assert load_from_file and beat_ready and count beats on beat_valid&beat_ready.
REQ-026 SHALL treat beat_valid=0 in LOAD as a stall: counter held, no timeout.
REQ-027 SHALL move LOAD to GAP on the edge where the accepted beat is number Ram_Depth/Para_Deg (8 by default).
REQ-028 SHALL, in GAP, hold for Gap_Cycles cycles with Mem_Index_reset asserted in the first GAP cycle, then enter COMPUTE.
REQ-029 SHALL, in COMPUTE, assert Computing for exactly Total_Computation_Steps cycles; step_count SHALL run 0..Total_Computation_Steps-1 and is 0 outside COMPUTE.
REQ-030 SHALL assert load_old_output throughout COMPUTE only when accumulate was latched 1.
REQ-031 SHALL, in DONE, assert done for 1 cycle and then return to IDLE.
REQ-032 SHALL ignore start when the state is not IDLE, and SHALL ignore beat_valid outside LOAD.
REQ-033 SHALL, on abort in any non-IDLE state, enter IDLE on the next edge with all controls deasserted and no done pulse.
REQ-034 SHALL give abort priority over start when both are asserted in the same cycle.
REQ-035 SHALL use a beat counter of Addr_Width bits and a step counter of Nums_Data_in_bits+1 bits, both cleared on every state entry.

Reset
REQ-036 SHALL, while reset=1, force state IDLE and clear all counters and latched flags.
REQ-037 SHALL, while reset=1, drive Mem_reset, Comp_reset, PE_reset and Mem_Index_reset to 1.
REQ-038 SHALL, while reset=1, drive all other outputs to 0.
REQ-039 SHALL give reset priority over abort and start, and SHALL treat reset asserted mid-job as an abort with no done pulse.

Verification
REQ-040 SHALL cover a full job: start with skip_load=0, beat_valid held 1 -> CLEAR 1 cycle, LOAD 8 cycles, GAP 2 cycles, Computing high 19 cycles, done on cycle 31 after the start edge.
REQ-041 SHALL cover load stalls: beat_valid low for 3 cycles mid-LOAD -> LOAD lasts 11 cycles, with exactly 8 beats accepted.
REQ-042 SHALL cover skip_load=1 with accumulate=1 -> Mem_reset never high, no LOAD, load_old_output high for all 19 COMPUTE cycles.
REQ-043 SHALL cover abort at COMPUTE step 5 -> IDLE next cycle, Computing 0, done never pulses, and a following start runs a full job.
REQ-044 SHALL cover reset in LOAD after 4 beats -> the four datapath resets are high, the state is 0, and the beat count restarts at 0 on the next job.
REQ-045 SHALL cover start pulsed while busy, and start with abort in IDLE -> both ignored; the job timing is unchanged.
